// File: rtl/alu_result_queue.sv
// ---------------------------------------------------------------------------
// alu_result_queue
//
// Registered output stage behind the 4-bit signed ALU. Each ALU result
// (opcode, 6-bit signed result, overflow, zero) is captured into a small
// first-word-fall-through FIFO with valid/ready handshakes on both sides.
// The block also keeps saturating counts of accepted overflow and zero
// results.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake; in_ready = (count != DEPTH)
//   in_opcode/result/overflow/zero   entry fields from the ALU
//   out_valid/out_ready downstream handshake; out_valid = (count != 0)
//   out_opcode/result/overflow/zero  head entry, read combinationally
//   count             number of occupied entries
//   clr_stats         synchronous clear of the statistics counters
//   ovf_cnt/zero_cnt  saturating counts of accepted overflow / zero entries
// ---------------------------------------------------------------------------
module alu_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_opcode,
    input  logic [5:0]                 in_result,
    input  logic                       in_overflow,
    input  logic                       in_zero,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_opcode,
    output logic [5:0]                 out_result,
    output logic                       out_overflow,
    output logic                       out_zero,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       clr_stats,
    output logic [CNT_W-1:0]           ovf_cnt,
    output logic [CNT_W-1:0]           zero_cnt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 11;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] STAT_MAX  = '1;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0]   zero_cnt_q, zero_cnt_d;

    logic               push;
    logic               pop;
    logic               ovf_hit;
    logic               zero_hit;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

    // All entries packed side by side so the read mux can index them with
    // the read pointer while each entry lives in its own generate scope.
    logic [DEPTH*ENTRY_W-1:0] mem_flat;

    // Handshake status comes from count alone; in_ready never looks at
    // out_ready, so a full queue refuses a push even while it is popping.
    assign in_ready  = (count_q != COUNT_MAX);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign ovf_hit   = push && in_overflow;
    assign zero_hit  = push && in_zero;
    assign wr_entry  = {in_opcode, in_result, in_overflow, in_zero};

    // ------------------------------------------------------------------
    // Storage: one register per entry, cleared by reset so the head reads
    // all zeros straight out of reset.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_q, entry_d;

            always_comb begin
                entry_d = entry_q;
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_d = wr_entry;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign mem_flat[gi*ENTRY_W +: ENTRY_W] = entry_q;
        end
    endgenerate

    // First-word-fall-through: the head is always presented, valid or not.
    assign head_entry   = mem_flat[rd_ptr_q*ENTRY_W +: ENTRY_W];
    assign out_opcode   = head_entry[10:8];
    assign out_result   = head_entry[7:2];
    assign out_overflow = head_entry[1];
    assign out_zero     = head_entry[0];

    // ------------------------------------------------------------------
    // Pointers and occupancy. DEPTH is a power of two, so natural binary
    // wrap of the pointers gives the modulo-DEPTH increment.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Statistics. A clear wins over the increment but still counts the
    // push that arrives in the clear cycle.
    // ------------------------------------------------------------------
    always_comb begin
        ovf_cnt_d  = ovf_cnt_q;
        zero_cnt_d = zero_cnt_q;

        if (clr_stats) begin
            ovf_cnt_d = CNT_W'(ovf_hit);
        end else if (ovf_hit && (ovf_cnt_q != STAT_MAX)) begin
            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end

        if (clr_stats) begin
            zero_cnt_d = CNT_W'(zero_hit);
        end else if (zero_hit && (zero_cnt_q != STAT_MAX)) begin
            zero_cnt_d = zero_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_cnt_q  <= '0;
            zero_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_cnt_q  <= ovf_cnt_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign count    = count_q;
    assign ovf_cnt  = ovf_cnt_q;
    assign zero_cnt = zero_cnt_q;

endmodule
